// File: rtl/i2c_target.sv
// i2c_target: I2C target exposing an 8-bit register pointer with byte write strobes and prefetched reads.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h68
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE} state_t;
  state_t      state_q;
  logic [1:0]  scl_s_q, sda_s_q;
  logic        scl_p_q, sda_p_q;
  logic [3:0]  cnt_q;
  logic [7:0]  sr_q, addr_q, wdata_q;
  logic        oe_q, we_q, re_q, load_q, busy_q, rw_q, ack_q;
  logic        scl, sda, start, stop, rise, fall;
  assign scl   = scl_s_q[1];
  assign sda   = sda_s_q[1];
  assign start = scl & scl_p_q & sda_p_q & ~sda;
  assign stop  = scl & scl_p_q & ~sda_p_q & sda;
  assign rise  = scl & ~scl_p_q;
  assign fall  = ~scl & scl_p_q;
  assign sda_oe    = oe_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      scl_s_q <= 2'b11;
      sda_s_q <= 2'b11;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
      cnt_q   <= '0;
      sr_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      rw_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      scl_s_q <= {scl_s_q[0], scl_in};
      sda_s_q <= {sda_s_q[0], sda_in};
      scl_p_q <= scl;
      sda_p_q <= sda;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      load_q  <= re_q;
      // read data arrives one clk after the request; it lands well before the next SCL fall
      if (load_q) sr_q <= reg_rdata;
      if (stop) begin
        state_q <= IDLE;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else if (start) begin
        state_q <= ADDR;
        cnt_q   <= '0;
        oe_q    <= 1'b0;
      end else begin
        case (state_q)
          ADDR, PTR, WR: begin
            if (rise) begin
              sr_q  <= {sr_q[6:0], sda};
              cnt_q <= cnt_q + 4'd1;
            end else if (fall && cnt_q == 4'd8) begin
              cnt_q <= '0;
              if (state_q == PTR) begin
                state_q <= PTR_ACK;
                oe_q    <= 1'b1;
                addr_q  <= sr_q;
              end else if (state_q == WR) begin
                state_q <= WR_ACK;
                oe_q    <= 1'b1;
                wdata_q <= sr_q;
                we_q    <= 1'b1;
              end else if (sr_q[7:1] == DEV_ADDR) begin
                state_q <= ADDR_ACK;
                oe_q    <= 1'b1;
                busy_q  <= 1'b1;
                rw_q    <= sr_q[0];
                re_q    <= sr_q[0];
              end else begin
                state_q <= IGNORE;
                oe_q    <= 1'b0;
              end
            end
          end
          ADDR_ACK: if (fall) begin
            state_q <= rw_q ? RD : PTR;
            cnt_q   <= '0;
            oe_q    <= rw_q & ~sr_q[7];
            sr_q    <= {sr_q[6:0], 1'b0};
          end
          PTR_ACK, WR_ACK: if (fall) begin
            state_q <= WR;
            cnt_q   <= '0;
            oe_q    <= 1'b0;
            addr_q  <= (state_q == WR_ACK) ? addr_q + 8'd1 : addr_q;
          end
          RD: begin
            if (rise) cnt_q <= cnt_q + 4'd1;
            else if (fall) begin
              state_q <= (cnt_q == 4'd8) ? RD_ACK : RD;
              oe_q    <= (cnt_q != 4'd8) & ~sr_q[7];
              sr_q    <= {sr_q[6:0], 1'b0};
            end
          end
          RD_ACK: begin
            if (rise) begin
              ack_q  <= ~sda;
              re_q   <= ~sda;
              addr_q <= sda ? addr_q : addr_q + 8'd1;
            end else if (fall) begin
              state_q <= ack_q ? RD : IGNORE;
              cnt_q   <= '0;
              oe_q    <= ack_q & ~sr_q[7];
              sr_q    <= {sr_q[6:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bus transactions with a scoreboard of expected register strobes.
module tb_i2c_target;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       msda = 1'b1;
  logic       sda_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] rdata = 8'h00;
  logic [7:0] mem [256];
  logic       sda_line;
  int         checks = 0;
  int         errors = 0;
  logic [15:0] we_exp [$];
  logic [7:0]  re_exp [$];
  logic        watch = 1'b0, oe_seen = 1'b0, busy_seen = 1'b0;
  logic [15:0] we_e;
  logic [7:0]  re_e;

  assign sda_line = msda & ~sda_oe;

  i2c_target #(.DEV_ADDR(7'h68)) dut (
    .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(rdata), .busy(busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (reg_re) rdata <= mem[reg_addr];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reg_we) begin
      we_e = (we_exp.size() != 0) ? we_exp.pop_front() : 16'hxxxx;
      chk("reg_we", {reg_addr, reg_wdata}, we_e);
    end
    if (reg_re) begin
      re_e = (re_exp.size() != 0) ? re_exp.pop_front() : 8'hxx;
      chk("reg_re", {8'h00, reg_addr}, {8'h00, re_e});
    end
    if (watch) begin
      oe_seen   = oe_seen | sda_oe;
      busy_seen = busy_seen | busy;
    end
  end

  task automatic wq();
    repeat (10) @(posedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic y);
    msda = b; wq();
    scl = 1'b1; wq();
    y = sda_line; wq();
    scl = 1'b0; wq();
  endtask

  task automatic start_c();
    msda = 1'b1; wq();
    scl = 1'b1; wq();
    msda = 1'b0; wq();
    scl = 1'b0; wq();
  endtask

  task automatic stop_c();
    msda = 1'b0; wq();
    scl = 1'b1; wq();
    msda = 1'b1; wq();
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic y;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], y);
    clk_bit(1'b1, ack);
    msda = 1'b1;
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] b);
    logic y;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, y);
      b[i] = y;
    end
    clk_bit(mack, y);
    msda = 1'b1;
  endtask

  initial begin
    logic a, y;
    logic [7:0] d;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h3B] = 8'hA5;
    mem[8'h3C] = 8'h5A;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_oe", {15'd0, sda_oe}, 16'd0);
    chk("rst_addr", {8'd0, reg_addr}, 16'd0);
    chk("rst_wdata", {8'd0, reg_wdata}, 16'd0);
    chk("rst_strobes", {14'd0, reg_we, reg_re}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    wq();
    // write two bytes starting at 0x6B
    we_exp.push_back({8'h6B, 8'h01});
    we_exp.push_back({8'h6C, 8'h02});
    start_c();
    wbyte(8'hD0, a); chk("wr_addr_ack", {15'd0, a}, 16'd0);
    chk("wr_busy", {15'd0, busy}, 16'd1);
    wbyte(8'h6B, a); chk("wr_ptr_ack", {15'd0, a}, 16'd0);
    wbyte(8'h01, a); chk("wr_d0_ack", {15'd0, a}, 16'd0);
    wbyte(8'h02, a); chk("wr_d1_ack", {15'd0, a}, 16'd0);
    stop_c();
    chk("wr_busy_end", {15'd0, busy}, 16'd0);
    chk("wr_ptr_end", {8'd0, reg_addr}, 16'h006D);
    // read two bytes from 0x3B via repeated START
    re_exp.push_back(8'h3B);
    re_exp.push_back(8'h3C);
    start_c();
    wbyte(8'hD0, a); chk("rd_addr_ack", {15'd0, a}, 16'd0);
    wbyte(8'h3B, a); chk("rd_ptr_ack", {15'd0, a}, 16'd0);
    start_c();
    wbyte(8'hD1, a); chk("rd_addr2_ack", {15'd0, a}, 16'd0);
    rbyte(1'b0, d); chk("rd_byte0", {8'd0, d}, 16'h00A5);
    rbyte(1'b1, d); chk("rd_byte1", {8'd0, d}, 16'h005A);
    stop_c();
    chk("rd_ptr_end", {8'd0, reg_addr}, 16'h003C);
    // foreign address is ignored entirely
    watch = 1'b1;
    start_c();
    wbyte(8'hA0, a); chk("mis_addr_nack", {15'd0, a}, 16'd1);
    wbyte(8'h55, a); chk("mis_data_nack", {15'd0, a}, 16'd1);
    stop_c();
    watch = 1'b0;
    chk("mis_oe_seen", {15'd0, oe_seen}, 16'd0);
    chk("mis_busy_seen", {15'd0, busy_seen}, 16'd0);
    // pointer wraps from 0xFF to 0x00
    we_exp.push_back({8'hFF, 8'h11});
    we_exp.push_back({8'h00, 8'h22});
    start_c();
    wbyte(8'hD0, a); chk("wrap_addr_ack", {15'd0, a}, 16'd0);
    wbyte(8'hFF, a); chk("wrap_ptr_ack", {15'd0, a}, 16'd0);
    wbyte(8'h11, a); chk("wrap_d0_ack", {15'd0, a}, 16'd0);
    wbyte(8'h22, a); chk("wrap_d1_ack", {15'd0, a}, 16'd0);
    stop_c();
    chk("wrap_ptr_end", {8'd0, reg_addr}, 16'h0001);
    // pointer-only write
    start_c();
    wbyte(8'hD0, a);
    wbyte(8'h42, a); chk("ptr_only_ack", {15'd0, a}, 16'd0);
    stop_c();
    chk("ptr_only_addr", {8'd0, reg_addr}, 16'h0042);
    // reset while the target drives a 0 data bit (bit6 of 0xA5)
    re_exp.push_back(8'h3B);
    start_c();
    wbyte(8'hD0, a);
    wbyte(8'h3B, a);
    start_c();
    wbyte(8'hD1, a); chk("rr_addr_ack", {15'd0, a}, 16'd0);
    clk_bit(1'b1, y); chk("rr_bit7", {15'd0, y}, 16'd1);
    chk("rr_driving", {15'd0, sda_oe}, 16'd1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("rr_oe_released", {15'd0, sda_oe}, 16'd0);
    chk("rr_busy", {15'd0, busy}, 16'd0);
    start_c();
    wbyte(8'hD0, a); chk("rr_after_ack", {15'd0, a}, 16'd0);
    wbyte(8'h10, a); chk("rr_after_ptr", {15'd0, a}, 16'd0);
    stop_c();
    chk("rr_ptr_end", {8'd0, reg_addr}, 16'h0010);
    wq();
    chk("we_pending", we_exp.size(), 16'd0);
    chk("re_pending", re_exp.size(), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
